// File: rtl/bus_master_if.sv
// -----------------------------------------------------------------------------
// bus_master_if
//
// Master-side bus interface between one CPU pipeline stage (IF or MEM) and the
// shared bus. A single word access from the pipeline is latched, the bus is
// requested from the arbiter, a one-cycle address strobe is issued on grant and
// the slave's ready/read data is awaited. A watchdog aborts accesses to slaves
// that never answer.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   stall        pipeline stall; holds a completed result in STALL
//   flush        pipeline flush; blocks acceptance of a new request in IDLE
//   if_as        pipeline access request
//   if_rw        1 = read, 0 = write
//   if_addr      word address (30 bits)
//   if_wr_data   write data (32 bits)
//   if_rd_data   read data returned to the pipeline (32 bits)
//   busy         pipeline must stall while high (combinational)
//   err          one-cycle pulse on watchdog abort
//   bus_req      request to the arbiter
//   bus_grnt     grant from the arbiter
//   bus_as       bus address strobe, high for the first ACCESS cycle only
//   bus_rw       bus read/write
//   bus_addr     bus word address (30 bits)
//   bus_wr_data  bus write data (32 bits)
//   bus_rd_data  read data from the slave read mux (32 bits)
//   bus_rdy      ready from the slave read mux
// -----------------------------------------------------------------------------
module bus_master_if #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        if_as,
    input  logic        if_rw,
    input  logic [29:0] if_addr,
    input  logic [31:0] if_wr_data,
    output logic [31:0] if_rd_data,
    output logic        busy,
    output logic        err,
    output logic        bus_req,
    input  logic        bus_grnt,
    output logic        bus_as,
    output logic        bus_rw,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } state_t;

    // A TIMEOUT of zero turns the watchdog off entirely.
    localparam bit               WD_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_as_q, bus_as_d;
    logic              bus_rw_q, bus_rw_d;
    logic [29:0]       bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wr_data_q, bus_wr_data_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              release_bus;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bus_req_q     <= 1'b0;
            bus_as_q      <= 1'b0;
            bus_rw_q      <= 1'b1;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            rd_data_q     <= '0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_as_q      <= bus_as_d;
            bus_rw_q      <= bus_rw_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_data_q     <= rd_data_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_as_d      = 1'b0;          // strobe lives for exactly one cycle
        bus_rw_d      = bus_rw_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_data_d     = rd_data_q;
        err_d         = 1'b0;          // err is a single-cycle pulse
        cnt_d         = cnt_q;
        release_bus   = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_as && !flush) begin
                    bus_rw_d      = if_rw;
                    bus_addr_d    = if_addr;
                    bus_wr_data_d = if_wr_data;
                    bus_req_d     = 1'b1;
                    state_d       = REQ;
                end
            end
            REQ: begin
                if (bus_grnt) begin
                    bus_as_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                // Ready is checked before the watchdog so a reply on the
                // boundary cycle completes normally.
                if (bus_rdy) begin
                    if (bus_rw_q) begin
                        rd_data_d = bus_rd_data;
                    end
                    release_bus = 1'b1;
                end else if (WD_EN && (cnt_q == CNT_LAST)) begin
                    err_d       = 1'b1;
                    rd_data_d   = '0;
                    release_bus = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STALL: begin
                if (!stall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion and abort share the same bus release, so the bus is
        // never held once the master leaves ACCESS.
        if (release_bus) begin
            bus_req_d     = 1'b0;
            bus_rw_d      = 1'b1;
            bus_addr_d    = '0;
            bus_wr_data_d = '0;
            state_d       = stall ? STALL : IDLE;
        end
    end

    assign busy = (state_q == REQ) || (state_q == ACCESS) ||
                  ((state_q == IDLE) && if_as && !flush);

    assign if_rd_data  = rd_data_q;
    assign err         = err_q;
    assign bus_req     = bus_req_q;
    assign bus_as      = bus_as_q;
    assign bus_rw      = bus_rw_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// -----------------------------------------------------------------------------
// tb_bus_master_if
//
// Bench for bus_master_if with TIMEOUT = 8. The arbiter and slave are played
// by the bench. Each transaction's expected waveform is derived from the
// access-level rules: REQ lasts grant-delay + 1 cycles, ACCESS lasts until
// ready or the watchdog limit, and the result/err follow on the next cycle.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bus_master_if;

    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        if_as;
    logic        if_rw;
    logic [29:0] if_addr;
    logic [31:0] if_wr_data;
    logic [31:0] if_rd_data;
    logic        busy;
    logic        err;
    logic        bus_req;
    logic        bus_grnt;
    logic        bus_as;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy;

    int          checks;
    int          errors;
    logic [31:0] exp_rd;   // pipeline-visible read data predicted by the model

    bus_master_if #(
        .TIMEOUT (TO),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .if_as       (if_as),
        .if_rw       (if_rw),
        .if_addr     (if_addr),
        .if_wr_data  (if_wr_data),
        .if_rd_data  (if_rd_data),
        .busy        (busy),
        .err         (err),
        .bus_req     (bus_req),
        .bus_grnt    (bus_grnt),
        .bus_as      (bus_as),
        .bus_rw      (bus_rw),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy     (bus_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access from acceptance in IDLE to return to IDLE.
    // g: REQ cycles before grant, w: ACCESS cycles before ready,
    // s: cycles spent in STALL after completion (0 = stall low).
    task automatic run_txn(input string tag, input logic rw, input logic [29:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int g, input int w, input int s);
        bit          to;
        int          n;
        int          j;
        logic [31:0] exp_after;
        logic [4:0]  exp_ctl;
        to        = (w + 1 > TO);
        n         = to ? TO : w + 1;
        exp_after = to ? 32'h0 : (rw ? rd : exp_rd);

        if_as = 1'b1; if_rw = rw; if_addr = addr; if_wr_data = wd;
        flush = 1'b0; stall = (s > 0); bus_grnt = 1'b0; bus_rdy = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s accept_busy: busy=%b expected 1", tag, busy);
        end

        for (int k = 1; k <= g + 1 + n; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scramble pipeline inputs: the bus side must hold latched values.
                if_as = 1'b0; if_rw = 1'($urandom); if_addr = 30'($urandom);
                if_wr_data = $urandom;
            end
            j = k - g - 1;
            exp_ctl = {1'b1, (j == 1), 1'b1, rw, 1'b0};
            checks++;
            if ({bus_req, bus_as, busy, bus_rw, err} !== exp_ctl) begin
                errors++;
                $display("FAIL %s ctl_cyc%0d: req/as/busy/rw/err=%b expected %b",
                         tag, k, {bus_req, bus_as, busy, bus_rw, err}, exp_ctl);
            end
            checks++;
            if ({bus_addr, bus_wr_data} !== {addr, wd}) begin
                errors++;
                $display("FAIL %s bus_hold_cyc%0d: addr=%h wdata=%h expected %h %h",
                         tag, k, bus_addr, bus_wr_data, addr, wd);
            end
            checks++;
            if (if_rd_data !== exp_rd) begin
                errors++;
                $display("FAIL %s rd_during_cyc%0d: if_rd_data=%h expected %h",
                         tag, k, if_rd_data, exp_rd);
            end
            flush = 1'($urandom);   // must not abort an in-flight access
            if (k <= g + 1) begin
                bus_grnt    = (k == g + 1);
                bus_rdy     = 1'b0;
                bus_rd_data = $urandom;
            end else begin
                bus_grnt    = 1'b0;
                bus_rdy     = (j == w + 1);
                bus_rd_data = bus_rdy ? rd : $urandom;
            end
        end

        @(negedge clk);
        bus_rdy = 1'b0; bus_rd_data = $urandom; flush = 1'b0;
        exp_rd = exp_after;
        checks++;
        if ({bus_req, bus_as, busy, bus_rw, bus_addr, bus_wr_data} !== {4'b0001, 62'h0}) begin
            errors++;
            $display("FAIL %s release: req/as/busy/rw=%b addr=%h wdata=%h expected 0001 0 0",
                     tag, {bus_req, bus_as, busy, bus_rw}, bus_addr, bus_wr_data);
        end
        checks++;
        if (err !== to) begin
            errors++; $display("FAIL %s err_pulse: err=%b expected %b", tag, err, to);
        end
        checks++;
        if (if_rd_data !== exp_rd) begin
            errors++;
            $display("FAIL %s result: if_rd_data=%h expected %h", tag, if_rd_data, exp_rd);
        end

        for (int i = 1; i <= s; i++) begin
            if (i > 1) begin
                @(negedge clk);
                checks++;
                if ({bus_req, err, if_rd_data} !== {2'b00, exp_rd}) begin
                    errors++;
                    $display("FAIL %s stall_hold%0d: req=%b err=%b rd=%h expected 0 0 %h",
                             tag, i, bus_req, err, if_rd_data, exp_rd);
                end
            end
            // A request in STALL must be neither accepted nor flagged busy.
            if_as = 1'b1; if_addr = 30'($urandom);
            #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL %s stall_busy%0d: busy=%b expected 0", tag, i, busy);
            end
            if (i == s) begin
                stall = 1'b0; if_as = 1'b0;
            end
        end
        if (s > 0) begin
            @(negedge clk);
            checks++;
            if ({bus_req, err, busy, if_rd_data} !== {3'b000, exp_rd}) begin
                errors++;
                $display("FAIL %s stall_exit: req=%b err=%b busy=%b rd=%h expected 0 0 0 %h",
                         tag, bus_req, err, busy, if_rd_data, exp_rd);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; if_as = 1'b0; if_rw = 1'b0;
        if_addr = '0; if_wr_data = '0; bus_grnt = 1'b0; bus_rd_data = '0; bus_rdy = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({bus_req, bus_as, busy, err, bus_rw, bus_addr, bus_wr_data, if_rd_data} !==
            {5'b00001, 94'h0}) begin
            errors++;
            $display("FAIL reset_values: req/as/busy/err/rw=%b addr=%h wd=%h rd=%h expected 00001 0 0 0",
                     {bus_req, bus_as, busy, err, bus_rw}, bus_addr, bus_wr_data, if_rd_data);
        end
        exp_rd = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        if_as = 1'b1; flush = 1'b1; if_rw = 1'b1; if_addr = 30'h155;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL flush_busy: busy=%b expected 0", busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus_req, busy, bus_as} !== 3'b000) begin
                errors++;
                $display("FAIL flush_ignore%0d: req/busy/as=%b expected 000", i, {bus_req, busy, bus_as});
            end
        end
        if_as = 1'b0; flush = 1'b0;
    endtask

    task automatic test_read_zero_wait();
        run_txn("read_zero_wait", 1'b1, 30'h0000100, 32'h0, 32'hDEADBEEF, 2, 0, 0);
    endtask

    task automatic test_write_wait();
        run_txn("write_wait3", 1'b0, 30'h2A5A5A5, 32'h12345678, 32'hFFFF0000, 1, 3, 0);
    endtask

    task automatic test_stall_hold();
        run_txn("stall_hold", 1'b1, 30'h0000040, 32'h0, 32'hA5A5A5A5, 0, 1, 4);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 1'b1, 30'h3FFFFFF, 32'h0, 32'h11111111, 1, 40, 0);
        run_txn("rdy_on_boundary", 1'b1, 30'h0000008, 32'h0, 32'hCAFEF00D, 0, TO - 1, 0);
        run_txn("timeout_stall", 1'b0, 30'h0000009, 32'h55AA55AA, 32'h0, 0, 40, 2);
    endtask

    task automatic test_grant_delay();
        run_txn("grant_delay", 1'b1, 30'h1234567, 32'h0, 32'h0BADF00D, 10, 2, 0);
    endtask

    task automatic test_reset_mid();
        if_as = 1'b1; if_rw = 1'b1; if_addr = 30'h77; flush = 1'b0; stall = 1'b0;
        @(negedge clk);                 // REQ
        if_as = 1'b0; bus_grnt = 1'b1;
        @(negedge clk);                 // ACCESS cycle 1
        bus_grnt = 1'b0; bus_rdy = 1'b0;
        checks++;
        if ({bus_as, bus_req} !== 2'b11) begin
            errors++; $display("FAIL reset_mid_access: as/req=%b expected 11", {bus_as, bus_req});
        end
        @(negedge clk);                 // ACCESS cycle 2
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({bus_req, bus_as, busy, err, bus_rw, bus_addr, bus_wr_data, if_rd_data} !==
            {5'b00001, 94'h0}) begin
            errors++;
            $display("FAIL reset_mid_values: req/as/busy/err/rw=%b addr=%h wd=%h rd=%h expected 00001 0 0 0",
                     {bus_req, bus_as, busy, err, bus_rw}, bus_addr, bus_wr_data, if_rd_data);
        end
        exp_rd = 32'h0;
        @(negedge clk);
        checks++;
        if ({bus_req, err} !== 2'b00) begin
            errors++; $display("FAIL reset_mid_after: req/err=%b expected 00", {bus_req, err});
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 30; t++) begin
            run_txn("random_b2b", 1'($urandom), 30'($urandom), $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 9),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1, "bench timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        exp_rd = 32'h0;
        test_reset();
        test_flush();
        test_read_zero_wait();
        test_write_wait();
        test_stall_hold();
        test_timeout();
        test_grant_delay();
        test_reset_mid();
        test_read_zero_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
